mempipe_arb: RTL
================

Name: mempipe_arb

Overview:
- Mem-pipe mm0 arbiter. Selects one request per cycle from LDQ entries and STQ entries and returns a same-cycle grant.
- Registers the winning t_mempipe_arb packet into the pipe as the mm1 stage.
- Sits directly downstream of every loadq_entry/storeq_entry e_pipe_req_mm0 / e_pipe_gnt_mm0 pair, and upstream of the mm1..mm5 pipe stages.

Parameters:
- LDQ_N, LDQ_NUM_ENTRIES, number of load-queue requesters.
- STQ_N, STQ_NUM_ENTRIES, number of store-queue requesters.
- STARVE_THRESH, 4, consecutive losing cycles for a requesting class before it is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ldq_req_mm0  in  LDQ_N  per-entry load pipe request.
- ldq_req_pkt_mm0  in  LDQ_N x t_mempipe_arb  per-entry load packet.
- ldq_gnt_mm0  out  LDQ_N  one-hot load grant, same cycle.
- stq_req_mm0  in  STQ_N  per-entry store pipe request.
- stq_req_pkt_mm0  in  STQ_N x t_mempipe_arb  per-entry store packet.
- stq_gnt_mm0  out  STQ_N  one-hot store grant, same cycle.
- pipe_stall_mm0  in  1  pipe cannot accept this cycle.
- nuke_rb1  in  t_nuke_pkt  ROB nuke; kills the mm1 packet if it is younger.
- pipe_valid_mm1  out  1  registered winner valid.
- pipe_req_pkt_mm1  out  t_mempipe_arb  registered winner packet.

Behaviour:
- Grant rules
  - At most one bit set across ldq_gnt_mm0 | stq_gnt_mm0.
  - No grant when pipe_stall_mm0 = 1 or when no requests are present.
  - Grants are combinational from the current-cycle requests and registered state.
- Intra-class selection: round-robin per class.
  - ldq_rr_ptr and stq_rr_ptr are each clog2(N) bits; both reset to 0.
  - Search starts at ptr and wraps modulo N.
  - On a grant in a class, that class's ptr becomes winner+1 mod N. Wrap: winner N-1 -> ptr 0.
  - The losing class's ptr holds.
- Inter-class selection, FSM cls_fsm, reset to ARB_LD_PRI:
  - ARB_LD_PRI: loads win when any ldq_req is present; otherwise stores.
  - ARB_ST_FORCE: stores win when any stq_req is present; otherwise loads.
  - ARB_LD_PRI -> ARB_ST_FORCE when st_starve_cnt reaches STARVE_THRESH-1 and a store loses this cycle.
  - ARB_ST_FORCE -> ARB_LD_PRI after any store grant, or when no stq_req is present.
- st_starve_cnt
  - Counts cycles with stq_req present, no store grant, and no stall.
  - Clears on a store grant or when no stq_req is present.
  - Saturates at STARVE_THRESH-1; resets to 0.
  - A stalled cycle neither increments nor clears the counter.
- mm1 register
  - pipe_valid_mm1 <= grant occurred, and not nuked.
  - pipe_req_pkt_mm1 <= the selected packet, loaded only on a grant (hold otherwise).
  - Nuke check: if nuke_rb1 is valid and the robid of pipe_req_pkt_mm1 is younger than or equal to the nuke robid (rob_defs age compare), pipe_valid_mm1 <= 0 on the next edge.
  - The same nuke check applies to the packet being granted this cycle. Its grant still asserts, so the entry advances, and the mm1 valid is suppressed.
- Reset
  - Reset forces pipe_valid_mm1 = 0, both ptrs = 0, counter = 0, FSM = ARB_LD_PRI, and all grants = 0.
  - Reset asserted mid-operation discards the in-flight mm1 packet; no grant issues during reset.
- Assertions (ASSERT): grant onehot0; any grant implies ~pipe_stall_mm0; every grant bit implies its req bit.

Optional Feature:
- Macro MEMPIPE_ARB_STARVE_EN.
- Defined: ARB_ST_FORCE and st_starve_cnt exist exactly as above.
- Undefined: strict load priority. cls_fsm and the counter are removed, and stores win only when ldq_req_mm0 == 0. The round-robin pointers are unchanged.

Decomposition:
- mem_defs.pkg: t_mempipe_arb (already present); t_arb_cls_fsm enum {ARB_LD_PRI, ARB_ST_FORCE}; STARVE_THRESH default constant.
- gen_funcs.pkg: a rotating find-first-set function.
- Sub-module: rr_pick. Parameterized width N; inputs req, ptr, en; outputs onehot gnt, any, next_ptr. Instantiated once for LDQ and once for STQ.

Test Plan:
- Single load, no stores: ldq_req_mm0[3]=1 -> ldq_gnt_mm0[3]=1 same cycle; next cycle pipe_valid_mm1=1, pipe_req_pkt_mm1.id=3, arb_type=MEM_LOAD; ldq_rr_ptr=4.
- RR wrap, LDQ_N=8, ptr=6, requests on entries 1,6,7 held: grants in order 6, 7, 1; ptr 7 -> 0 -> 2.
- Starvation (EN, THRESH=4), all loads and stq[2] requesting continuously:
  - Loads granted cycles 0..3; stq_gnt_mm0[2]=1 on cycle 4; loads resume on cycle 5.
  - Same stimulus without the macro: no store grant ever.
- Stall: pipe_stall_mm0=1 for 3 cycles with requests present -> all grants 0, pipe_valid_mm1=0, ptrs and counter held; first cycle after the stall grants normally.
- Nuke, mm1 robid=10: nuke_rb1 with robid 8 -> pipe_valid_mm1 drops next cycle; nuke robid 12 (younger than 10) -> the packet survives.
- Reset mid-run with pipe_valid_mm1=1 and ptr=5: reset pulse -> pipe_valid_mm1=0, ptrs=0, FSM=ARB_LD_PRI, and no grants during reset.

Source files
------------

// File: rtl/mempipe_arb_pkg.sv
// rtl/mempipe_arb_pkg.sv - mem-pipe arbiter types, defaults and helper functions
package mempipe_arb_pkg;

    localparam int LDQ_NUM_ENTRIES       = 8;
    localparam int STQ_NUM_ENTRIES       = 8;
    localparam int STARVE_THRESH_DEFAULT = 4;
    localparam int ROBID_W               = 6;

    typedef enum logic {MEM_LOAD, MEM_STORE} t_mem_type;

    typedef struct packed {
        t_mem_type            arb_type;
        logic [4:0]           id;
        logic [ROBID_W-1:0]   robid;
    } t_mempipe_arb;

    typedef struct packed {
        logic                 valid;
        logic [ROBID_W-1:0]   robid;
    } t_nuke_pkt;

    typedef enum logic {ARB_LD_PRI, ARB_ST_FORCE} t_arb_cls_fsm;

    // First set bit of req at or after ptr, wrapping modulo n (n <= 32).
    function automatic logic [4:0] rot_ffs(input logic [31:0] req, input logic [4:0] ptr, input int n);
        logic [4:0] res;
        logic       found;
        int         idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx[4:0]]) begin
                res   = idx[4:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Robids carry a wrap bit in the MSB; a is younger than or equal to b.
    function automatic logic rob_younger_or_eq(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1])
            return a[ROBID_W-2:0] >= b[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    endfunction

endpackage

// File: rtl/mempipe_arb_rr_pick.sv
// rtl/mempipe_arb_rr_pick.sv - round-robin one-hot picker with next-pointer
module mempipe_arb_rr_pick
    import mempipe_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [PW-1:0] next_ptr
);

    logic [31:0]   req_ext;
    logic [4:0]    win;
    logic [PW-1:0] w;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
    end

    assign any = |req;
    assign win = rot_ffs(req_ext, 5'(ptr), N);
    assign w   = PW'(win);

    always_comb begin
        gnt = '0;
        if (en && any)
            gnt[w] = 1'b1;
    end

    assign next_ptr = (int'(w) == N - 1) ? '0 : w + PW'(1);

endmodule

// File: rtl/mempipe_arb.sv
// rtl/mempipe_arb.sv - mm0 load/store pipe arbiter with mm1 register; MEMPIPE_ARB_STARVE_EN enables store anti-starvation
module mempipe_arb
    import mempipe_arb_pkg::*;
#(
    parameter int LDQ_N = LDQ_NUM_ENTRIES,
`ifdef MEMPIPE_ARB_STARVE_EN
    parameter int STARVE_THRESH = STARVE_THRESH_DEFAULT,
`endif
    parameter int STQ_N = STQ_NUM_ENTRIES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LDQ_N-1:0]            ldq_req_mm0,
    input  t_mempipe_arb [LDQ_N-1:0]    ldq_req_pkt_mm0,
    output logic [LDQ_N-1:0]            ldq_gnt_mm0,
    input  logic [STQ_N-1:0]            stq_req_mm0,
    input  t_mempipe_arb [STQ_N-1:0]    stq_req_pkt_mm0,
    output logic [STQ_N-1:0]            stq_gnt_mm0,
    input  logic                        pipe_stall_mm0,
    input  t_nuke_pkt                   nuke_rb1,
    output logic                        pipe_valid_mm1,
    output t_mempipe_arb                pipe_req_pkt_mm1
);

    localparam int LPW = (LDQ_N > 1) ? $clog2(LDQ_N) : 1;
    localparam int SPW = (STQ_N > 1) ? $clog2(STQ_N) : 1;

    logic [LPW-1:0] ldq_rr_ptr, ld_next_ptr;
    logic [SPW-1:0] stq_rr_ptr, st_next_ptr;
    logic           ld_any, st_any, ld_cls, st_cls, ld_en, st_en, any_gnt;
    t_mempipe_arb   sel_pkt;

`ifdef MEMPIPE_ARB_STARVE_EN
    localparam int CW = (STARVE_THRESH > 2) ? $clog2(STARVE_THRESH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_THRESH - 1);

    t_arb_cls_fsm  cls_state, cls_next;
    logic [CW-1:0] st_starve_cnt, cnt_next;
    logic          st_loses;

    assign ld_cls   = ld_any && (cls_state == ARB_LD_PRI || !st_any);
    assign st_loses = st_any && !st_en && !pipe_stall_mm0;

    always_comb begin
        cnt_next = st_starve_cnt;
        cls_next = cls_state;
        if (!pipe_stall_mm0) begin
            if (!st_any || st_en)
                cnt_next = '0;
            else if (st_starve_cnt != CNT_MAX)
                cnt_next = st_starve_cnt + 1'b1;
        end
        case (cls_state)
            ARB_LD_PRI:   if (st_loses && st_starve_cnt == CNT_MAX) cls_next = ARB_ST_FORCE;
            ARB_ST_FORCE: if (st_en || !st_any) cls_next = ARB_LD_PRI;
            default:      cls_next = ARB_LD_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cls_state     <= ARB_LD_PRI;
            st_starve_cnt <= '0;
        end else begin
            cls_state     <= cls_next;
            st_starve_cnt <= cnt_next;
        end
    end
`else
    assign ld_cls = ld_any;
`endif

    assign st_cls  = st_any && !ld_cls;
    // Reset gates the grants so no queue entry advances while the pipe is cleared.
    assign ld_en   = !reset && !pipe_stall_mm0 && ld_cls;
    assign st_en   = !reset && !pipe_stall_mm0 && st_cls;
    assign any_gnt = ld_en || st_en;

    mempipe_arb_rr_pick #(.N(LDQ_N), .PW(LPW)) u_ld_pick (
        .req      (ldq_req_mm0),
        .ptr      (ldq_rr_ptr),
        .en       (ld_en),
        .gnt      (ldq_gnt_mm0),
        .any      (ld_any),
        .next_ptr (ld_next_ptr)
    );

    mempipe_arb_rr_pick #(.N(STQ_N), .PW(SPW)) u_st_pick (
        .req      (stq_req_mm0),
        .ptr      (stq_rr_ptr),
        .en       (st_en),
        .gnt      (stq_gnt_mm0),
        .any      (st_any),
        .next_ptr (st_next_ptr)
    );

    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < LDQ_N; i++)
            if (ldq_gnt_mm0[i]) sel_pkt = ldq_req_pkt_mm0[i];
        for (int i = 0; i < STQ_N; i++)
            if (stq_gnt_mm0[i]) sel_pkt = stq_req_pkt_mm0[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ldq_rr_ptr       <= '0;
            stq_rr_ptr       <= '0;
            pipe_valid_mm1   <= 1'b0;
            pipe_req_pkt_mm1 <= '0;
        end else begin
            if (ld_en) ldq_rr_ptr <= ld_next_ptr;
            if (st_en) stq_rr_ptr <= st_next_ptr;
            // A nuked winner still consumes its grant; only the mm1 valid is dropped.
            if (any_gnt) begin
                pipe_req_pkt_mm1 <= sel_pkt;
                pipe_valid_mm1   <= !(nuke_rb1.valid && rob_younger_or_eq(sel_pkt.robid, nuke_rb1.robid));
            end else begin
                pipe_valid_mm1   <= 1'b0;
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0({ldq_gnt_mm0, stq_gnt_mm0}));
    a_gnt_no_stall: assert property (@(posedge clk) disable iff (reset)
        (|{ldq_gnt_mm0, stq_gnt_mm0}) |-> !pipe_stall_mm0);
    a_gnt_has_req: assert property (@(posedge clk) disable iff (reset)
        ((ldq_gnt_mm0 & ~ldq_req_mm0) == '0) && ((stq_gnt_mm0 & ~stq_req_mm0) == '0));

endmodule
